// File: rtl/ram_stream_ctrl.sv
// Streaming FIFO controller that owns a 16x8 single-port synchronous RAM.
// One RAM access per cycle (reads win); read data lands in a one-entry output register.
module ram_stream_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic rd_go;
    logic wr_go;

    // A read may only launch when the output register will be free by capture time.
    always_comb begin
        rd_go    = (count_q != '0) && !rd_inflight_q && (!out_valid_q || out_ready);
        in_ready = rst_n && (count_q != DEPTH_C) && !rd_go;
        wr_go    = in_valid && in_ready;

        ram_we   = wr_go;
        ram_addr = wr_go ? wr_ptr_q : rd_ptr_q;
        ram_din  = in_data;
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        rd_inflight_d = rd_inflight_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;

        if (rd_inflight_q) begin
            out_data_d    = ram_dout;
            out_valid_d   = 1'b1;
            rd_inflight_d = 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (rd_go) begin
            rd_ptr_d      = rd_ptr_q + ADDR_W'(1);
            count_d       = count_q - (ADDR_W + 1)'(1);
            rd_inflight_d = 1'b1;
        end else if (wr_go) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            count_d  = count_q + (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rd_inflight_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rd_inflight_q <= rd_inflight_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0) && !rd_inflight_q && !out_valid_q;

endmodule

// File: doc/ram_stream_ctrl.md
Name: ram_stream_ctrl

Overview:
- Streaming FIFO controller that sits directly in front of the 16x8 single-port synchronous RAM (ports clk, we, addr, din, dout) and owns its whole port.
- Upstream ready/valid producer writes words in; downstream ready/valid consumer receives them in order.
- The RAM's registered read data is captured into a one-entry output register.
- Issues exactly one RAM access (read or write) per cycle, because the RAM has a single address port.

Parameters:
- DATA_W, 8, word width; must match RAM data width.
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W (16), derived, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream word present.
- in_data  input  DATA_W  upstream word.
- in_ready  output  1  controller accepts in_data this cycle.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  DATA_W  oldest word.
- out_ready  input  1  downstream consumes out_data this cycle.
- ram_we  output  1  drives RAM we.
- ram_addr  output  ADDR_W  drives RAM addr.
- ram_din  output  DATA_W  drives RAM din.
- ram_dout  input  DATA_W  from RAM dout (1-cycle registered read).
- count  output  ADDR_W+1  words resident in RAM (0..DEPTH); excludes in-flight and output-register words.
- full  output  1  count == DEPTH.
- empty  output  1  count==0 && no read in flight && !out_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n low at a rising edge) clears the following:
  - wr_ptr=0, rd_ptr=0, count=0.
  - rd_inflight=0, out_valid=0, out_data=0.
  - While rst_n is low: ram_we=0, in_ready=0.
  - A read in flight during reset is discarded. RAM contents are not cleared.
- Internal state: wr_ptr, rd_ptr (ADDR_W bits, wrap DEPTH-1 -> 0), count, rd_inflight (1 bit).
- Read issue condition (rd_go): count>0 && !rd_inflight && (!out_valid || out_ready).
- Per-cycle port decision is combinational, with read priority:
  - If rd_go: ram_we=0, ram_addr=rd_ptr. At the edge: rd_ptr++, count--, rd_inflight<=1.
  - Else if in_valid && in_ready: ram_we=1, ram_addr=wr_ptr, ram_din=in_data. At the edge: wr_ptr++, count++.
  - Else (idle): ram_we=0, ram_addr=rd_ptr, ram_din=in_data.
- in_ready = rst_n && count<DEPTH && !rd_go. This path is combinational through out_ready.
- Read and write never occur in the same cycle, so count never has simultaneous increment and decrement. Read-during-write ordering of the RAM is irrelevant.
- Capture: when rd_inflight=1, ram_dout is loaded into out_data at the edge, out_valid<=1, rd_inflight<=0.
- The rd_go gating guarantees the output register is free at capture time.
- Pop: out_valid && out_ready at an edge with no capture -> out_valid<=0.
- Backpressure: while out_valid && !out_ready, out_data is held stable.
- Latency: a word accepted in cycle 0 on an empty controller gives out_valid=1 in cycle 3:
  - cycle 0: write.
  - cycle 1: read issued.
  - cycle 2: capture.
  - cycle 3: out_valid=1.
- Throughput: at most one read per 2 cycles (no second read while one is in flight). Writes fill the idle port cycles, so there is no starvation in either direction.
- Capacity: DEPTH words in RAM plus 1 in the output register (17 total).
- Order is strictly FIFO across pointer wrap.

Test Plan:
- Reset, push 0xA5 once, out_ready=0 -> out_valid rises exactly in cycle 3, out_data=0xA5, count returns to 0. Pop -> empty=1 next cycle.
- in_valid held high with data 0x00,0x01,..., out_ready=0 -> exactly 17 words accepted; then in_ready=0, full=1, count=16, out_data=0x00 held stable.
- From full, out_ready=1, no pushes -> words 0x00..0x10 emerge in order, one per 2 cycles, rd_ptr wraps 15->0. Final state: empty=1, count=0.
- Continuous in_valid and out_ready for 50 words (random data) -> no loss, no duplication, order preserved. in_ready=0 exactly on read-issue cycles. ram_we never high in a read cycle.
- Random out_ready toggling while out_valid=1 -> out_data unchanged on every stalled cycle; a capture never overwrites an unconsumed word.
- With count=5 and a read in flight, drive rst_n=0 for 1 cycle -> next cycle out_valid=0, count=0, empty=1, ram_we=0. Then push 0x3C -> first word out is 0x3C.
